// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and flag bit positions for the ALU controller.
// Pure declarations: no latency, no flow control.
package alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_SHL  = 3'd5;
   localparam logic [2:0] OP_SHR  = 3'd6;
   localparam logic [2:0] OP_PASS = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EXEC  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int FLG_C = 3;
   localparam int FLG_N = 2;
   localparam int FLG_Z = 1;
   localparam int FLG_V = 0;

endpackage

// File: rtl/alu_flag_gen.sv
// Architectural {C,N,Z,V} flags from the operands, the captured result and the shift carry.
// Combinational, zero latency; no flow control.
module alu_flag_gen
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] r,
   input  logic             sh_c,
   output logic [3:0]       flags
);

   localparam int MSB = WIDTH - 1;

   always_comb begin
      flags        = '0;
      flags[FLG_Z] = (r == '0);
      flags[FLG_N] = r[MSB];
      case (op)
         OP_ADD: begin
            flags[FLG_C] = (r < a);
            flags[FLG_V] = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
         end
         OP_SUB: begin
            flags[FLG_C] = (a < b);
            flags[FLG_V] = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
         end
         OP_SHL, OP_SHR: flags[FLG_C] = sh_c;
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_controller.sv
// Sequences one ALU op at a time: 2-cycle latency, shifts shamt+1 (1 bit per cycle).
// Response held in DONE until rsp_ready; req_ready only in IDLE.
module alu_controller
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] add_in,
   input  logic [WIDTH-1:0] sub_in,
   input  logic [WIDTH-1:0] and_in,
   input  logic [WIDTH-1:0] or_in,
   input  logic [WIDTH-1:0] xor_in,
   input  logic [WIDTH-1:0] sfl_in,
   input  logic [WIDTH-1:0] sfr_in,
   input  logic [WIDTH-1:0] chk_in,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic [3:0]       rsp_flags,
   output logic             busy
);

   state_t               state_q, state_d;
   logic [2:0]           op_q, op_d;
   logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, acc_q, acc_d;
   logic [SHAMT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]     rsp_data_q, rsp_data_d;
   logic [3:0]           rsp_flags_q, rsp_flags_d;

   logic [SHAMT_W-1:0]   req_shamt;
   logic                 req_is_shift;
   logic [WIDTH-1:0]     exec_res, shift_res, cap_res;
   logic                 shift_c, cap_c;
   logic [3:0]           cap_flags;

   assign req_shamt    = req_b[SHAMT_W-1:0];
   assign req_is_shift = (req_op == OP_SHL) || (req_op == OP_SHR);

   // A shift reaching EXEC always has shamt==0, so its result is A unchanged.
   always_comb begin
      exec_res = chk_in;
      case (op_q)
         OP_ADD:         exec_res = add_in;
         OP_SUB:         exec_res = sub_in;
         OP_AND:         exec_res = and_in;
         OP_OR:          exec_res = or_in;
         OP_XOR:         exec_res = xor_in;
         OP_SHL, OP_SHR: exec_res = a_q;
         default:        exec_res = chk_in;
      endcase
   end

   assign shift_res = (op_q == OP_SHL) ? sfl_in : sfr_in;
   assign shift_c   = (op_q == OP_SHL) ? acc_q[WIDTH-1] : acc_q[0];
   assign cap_res   = (state_q == S_SHIFT) ? shift_res : exec_res;
   assign cap_c     = (state_q == S_SHIFT) && shift_c;

   alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
      .op    (op_q),
      .a     (a_q),
      .b     (b_q),
      .r     (cap_res),
      .sh_c  (cap_c),
      .flags (cap_flags)
   );

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      rsp_data_d  = rsp_data_q;
      rsp_flags_d = rsp_flags_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d    = req_op;
               a_d     = req_a;
               b_d     = req_b;
               acc_d   = req_a;
               cnt_d   = req_shamt;
               state_d = (req_is_shift && (req_shamt != '0)) ? S_SHIFT : S_EXEC;
            end
         end
         S_EXEC: begin
            rsp_data_d  = cap_res;
            rsp_flags_d = cap_flags;
            state_d     = S_DONE;
         end
         S_SHIFT: begin
            acc_d = shift_res;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == SHAMT_W'(1)) begin
               rsp_data_d  = cap_res;
               rsp_flags_d = cap_flags;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         rsp_data_q  <= '0;
         rsp_flags_q <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         rsp_data_q  <= rsp_data_d;
         rsp_flags_q <= rsp_flags_d;
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign rsp_data  = rsp_data_q;
   assign rsp_flags = rsp_flags_q;
   assign alu_a     = (state_q == S_EXEC)  ? a_q :
                      (state_q == S_SHIFT) ? acc_q : '0;
   assign alu_b     = (state_q == S_EXEC)  ? b_q : '0;

endmodule
